// File: rtl/precision_pkg.sv
// Shared types and helpers for the block-floating-point precision tracker.
// Bank states, precision width, and the clamp applied to the reported width.
package precision_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    localparam int PREC_W            = 8;
    localparam int BLOCK_LEN_DEFAULT = 16;
    localparam int IDX_W             = $clog2(BLOCK_LEN_DEFAULT);

    function automatic logic [PREC_W-1:0] clamp_prec(
        input logic [PREC_W-1:0] p,
        input logic [PREC_W-1:0] floor_p
    );
        return (p < floor_p) ? floor_p : p;
    endfunction

    // Index width for a block of len samples; never narrower than one bit.
    function automatic int idx_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/msb_index.sv
// Combinational priority encoder: index of the highest set bit plus a zero flag.
module msb_index #(
    parameter int WIDTH = 19,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] value,
    output logic [IW-1:0]    index,
    output logic             zero
);

    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                index = IW'(i);
            end
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/block_precision_tracker.sv
// Double-buffered block precision tracker: stores a block, finds its minimum
// bit width, then replays the samples with that width on current_precision.
module block_precision_tracker
    import precision_pkg::*;
#(
    parameter int WIDTH_IN      = 19,
    parameter int BLOCK_LEN     = 16,
    parameter int MIN_PRECISION = 16,
    parameter int IS_SIGNED     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH_IN-1:0] din,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH_IN-1:0] dout,
    output logic [7:0]          current_precision,
    output logic                out_last
);

    localparam int AW = idx_width(BLOCK_LEN);
    localparam int HW = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1;
    localparam logic [AW-1:0]     IDX_LAST   = AW'(BLOCK_LEN - 1);
    localparam logic [PREC_W-1:0] SIGN_ADJ   = (IS_SIGNED != 0) ? PREC_W'(2) : PREC_W'(1);
    localparam logic [PREC_W-1:0] PREC_FLOOR = PREC_W'(MIN_PRECISION);

    logic                         wr_ptr_q, wr_ptr_d;
    logic                         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]                wr_idx_q, wr_idx_d;
    logic [AW-1:0]                rd_idx_q, rd_idx_d;
    logic [WIDTH_IN-1:0]          mem_q [2][BLOCK_LEN];
    logic [1:0]                   bank_writable;
    logic [1:0]                   bank_readable;
    logic [1:0][PREC_W-1:0]       bank_prec;
    logic                         in_fire, out_fire, wr_last, rd_last;
    logic [WIDTH_IN-1:0]          din_mag;

    // rst_n gates in_ready so nothing is offered while reset is held.
    assign in_ready  = rst_n & bank_writable[wr_ptr_q];
    assign out_valid = bank_readable[rd_ptr_q];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign wr_last   = (wr_idx_q == IDX_LAST);
    assign rd_last   = (rd_idx_q == IDX_LAST);

    // Folding negatives to ~x makes the OR of magnitudes track the sign bit position.
    assign din_mag = ((IS_SIGNED != 0) && din[WIDTH_IN-1]) ? ~din : din;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_idx_d = wr_idx_q;
        rd_ptr_d = rd_ptr_q;
        rd_idx_d = rd_idx_q;
        if (in_fire) begin
            if (wr_last) begin
                wr_idx_d = '0;
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (out_fire) begin
            if (rd_last) begin
                rd_idx_d = '0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[wr_ptr_q][wr_idx_q] <= din;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        bank_state_t         state_q, state_d;
        logic [WIDTH_IN-1:0] m_q, m_d;
        logic [PREC_W-1:0]   prec_q, prec_d, prec_raw;
        logic [HW-1:0]       top_bit;
        logic                m_zero;
        logic                wr_sel, rd_sel;

        assign wr_sel = in_fire && (wr_ptr_q == 1'(gi));
        assign rd_sel = out_fire && (rd_ptr_q == 1'(gi));

        // Encoder sees m_d so the block's final sample is part of the result.
        msb_index #(.WIDTH(WIDTH_IN)) u_msb (
            .value (m_d),
            .index (top_bit),
            .zero  (m_zero)
        );

        assign prec_raw = m_zero ? PREC_W'(1) : (PREC_W'(top_bit) + SIGN_ADJ);

        always_comb begin
            state_d = state_q;
            m_d     = m_q;
            prec_d  = prec_q;
            if (wr_sel) begin
                m_d = (state_q == EMPTY) ? din_mag : (m_q | din_mag);
                if (wr_last) begin
                    state_d = FULL;
                    prec_d  = clamp_prec(prec_raw, PREC_FLOOR);
                end else begin
                    state_d = FILLING;
                end
            end
            if (rd_sel) begin
                state_d = rd_last ? EMPTY : DRAINING;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= EMPTY;
                m_q     <= '0;
                prec_q  <= '0;
            end else begin
                state_q <= state_d;
                m_q     <= m_d;
                prec_q  <= prec_d;
            end
        end

        assign bank_writable[gi] = (state_q == EMPTY) || (state_q == FILLING);
        assign bank_readable[gi] = (state_q == FULL) || (state_q == DRAINING);
        assign bank_prec[gi]     = prec_q;
    end

    assign dout              = out_valid ? mem_q[rd_ptr_q][rd_idx_q] : '0;
    assign current_precision = out_valid ? bank_prec[rd_ptr_q] : '0;
    assign out_last          = out_valid & rd_last;

endmodule

// File: tb/tb_block_precision_tracker.sv
// Bench for block_precision_tracker: three instances (signed/floor 1, signed/floor 16,
// unsigned/floor 1) share one stimulus stream and are checked against a range model.
module tb_block_precision_tracker;

    localparam int W    = 19;
    localparam int BL   = 4;
    localparam int NCFG = 3;

    typedef struct packed {
        logic [2:0][W-1:0] d;
        logic [2:0][7:0]   p;
        logic [2:0]        l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] din = '0;
    logic         in_rdy  [NCFG];
    logic         out_vld [NCFG];
    logic [W-1:0] dout_w  [NCFG];
    logic [7:0]   prec_w  [NCFG];
    logic         last_w  [NCFG];

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] blk[$];
    beat_t        exp_q[$];
    beat_t        obs_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        block_precision_tracker #(
            .WIDTH_IN      (W),
            .BLOCK_LEN     (BL),
            .MIN_PRECISION ((gi == 1) ? 16 : 1),
            .IS_SIGNED     ((gi == 2) ? 0 : 1)
        ) dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .in_valid          (in_valid),
            .in_ready          (in_rdy[gi]),
            .din               (din),
            .out_valid         (out_vld[gi]),
            .out_ready         (out_ready),
            .dout              (dout_w[gi]),
            .current_precision (prec_w[gi]),
            .out_last          (last_w[gi])
        );
    end

    // Smallest width whose representable range contains x.
    function automatic int bits_needed(input logic [W-1:0] x, input bit sgn);
        int v;
        int p;
        v = sgn ? int'($signed(x)) : int'(x);
        p = 1;
        if (sgn) begin
            while (v < -(1 << (p - 1)) || v > (1 << (p - 1)) - 1) p++;
        end else begin
            while (v >= (1 << p)) p++;
        end
        return p;
    endfunction

    function automatic logic [W-1:0] rand_sample(input int w);
        int v;
        v = int'($urandom());
        v = v >>> (32 - w);
        return v[W-1:0];
    endfunction

    task automatic close_block();
        beat_t b;
        int    need [NCFG];
        for (int k = 0; k < NCFG; k++) begin
            need[k] = (k == 1) ? 16 : 1;
            for (int i = 0; i < BL; i++) begin
                if (bits_needed(blk[i], k != 2) > need[k]) need[k] = bits_needed(blk[i], k != 2);
            end
        end
        for (int i = 0; i < BL; i++) begin
            for (int k = 0; k < NCFG; k++) begin
                b.d[k] = blk[i];
                b.p[k] = 8'(need[k]);
            end
            b.l = (i == BL - 1) ? 3'b111 : 3'b000;
            exp_q.push_back(b);
        end
        blk.delete();
    endtask

    // One clock of stimulus; records accepted inputs into the model and emitted beats.
    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy,
                         output bit acc, output bit emit);
        beat_t b;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        #1;
        acc  = iv && in_rdy[0];
        emit = out_vld[0] && ordy;
        if (acc) begin
            blk.push_back(d);
            if (blk.size() == BL) close_block();
        end
        if (emit) begin
            for (int k = 0; k < NCFG; k++) begin
                b.d[k] = dout_w[k];
                b.p[k] = prec_w[k];
                b.l[k] = last_w[k];
            end
            obs_q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_checks++;
            if (in_rdy[k] !== 1'b0 || out_vld[k] !== 1'b0 || dout_w[k] !== '0 ||
                prec_w[k] !== 8'd0 || last_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state cfg%0d: got rdy=%b vld=%b d=%h p=%0d last=%b, expected all 0",
                         k, in_rdy[k], out_vld[k], dout_w[k], prec_w[k], last_w[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_checks++;
            if (in_rdy[k] !== 1'b1 || out_vld[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release cfg%0d: got rdy=%b vld=%b, expected rdy=1 vld=0",
                         k, in_rdy[k], out_vld[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [W-1:0]    vals [BL];
        logic [2:0][7:0] anc;
        beat_t           o, e;
        bit              acc, emit;
        int              i;
        vals = '{19'd100, 19'h7FF38, 19'd0, 19'd5};
        anc  = {8'd19, 8'd16, 8'd9};
        for (int c = 0; c < BL; c++) begin
            cycle(1'b1, vals[c], 1'b1, acc, emit);
            n_checks++;
            if (acc !== 1'b1 || out_vld[0] !== (c == BL - 1)) begin
                n_fail++;
                $display("FAIL basic_latency c%0d: got acc=%b vld=%b, expected acc=1 vld=%b",
                         c, acc, out_vld[0], (c == BL - 1));
            end
        end
        repeat (BL + 2) cycle(1'b0, '0, 1'b1, acc, emit);
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("basic beat %0d: d=%h p=%h last=%b", i, o.d[0], o.p, o.l);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_beat %0d: got %h, expected %h", i, o, e);
            end
            if (i == 0) begin
                n_checks++;
                if (o.p !== anc) begin
                    n_fail++;
                    $display("FAIL basic_prec: got %h, expected %h", o.p, anc);
                end
            end
            i++;
        end
        n_checks++;
        if (i != BL || obs_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_count: got %0d beats (+%0d extra), expected %0d (%0d missing)",
                     i, obs_q.size(), BL, exp_q.size());
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0]    vals [16];
        logic [2:0][7:0] anc [4];
        logic [W-1:0]    d;
        beat_t           o, e;
        bit              acc, emit;
        int              idx, i;
        vals = '{19'd0, 19'd0, 19'd0, 19'd0,
                 19'h40000, 19'd0, 19'd0, 19'd0,
                 19'd3, 19'd8, 19'd1, 19'd0,
                 19'h7FFFF, 19'h7FFFF, 19'd0, 19'd1};
        anc  = '{{8'd1, 8'd16, 8'd1}, {8'd19, 8'd19, 8'd19},
                 {8'd4, 8'd16, 8'd5}, {8'd19, 8'd16, 8'd2}};
        idx = 0;
        for (int c = 0; c < 60 && (idx < 16 || obs_q.size() < 16); c++) begin
            if (idx < 16) d = vals[idx];
            else d = '0;
            cycle(idx < 16, d, 1'b1, acc, emit);
            if (acc) idx++;
        end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("bound beat %0d: d=%h p=%h last=%b", i, o.d[0], o.p, o.l);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bound_beat %0d: got %h, expected %h", i, o, e);
            end
            if (i % BL == 0) begin
                n_checks++;
                if (o.p !== anc[i / BL]) begin
                    n_fail++;
                    $display("FAIL bound_prec blk%0d: got %h, expected %h", i / BL, o.p, anc[i / BL]);
                end
            end
            i++;
        end
        n_checks++;
        if (i != 16 || obs_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bound_count: got %0d beats, expected 16 (%0d missing)", i, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vals [12];
        logic [W-1:0] d;
        logic [W+9:0] snap;
        beat_t        o, e;
        bit           acc, emit;
        int           idx, emits, i;
        snap = '0;
        for (int k = 0; k < 12; k++) vals[k] = rand_sample(int'($urandom_range(1, W)));
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (idx < 12) d = vals[idx];
            else d = '0;
            cycle(idx < 12, d, 1'b0, acc, emit);
            if (acc) idx++;
            if (c == 10) snap = {out_vld[0], dout_w[0], prec_w[0], last_w[0]};
        end
        n_checks++;
        if (idx != 8) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d samples, expected 8", idx);
        end
        n_checks++;
        if (in_rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b, expected 0", in_rdy[0]);
        end
        n_checks++;
        if ({out_vld[0], dout_w[0], prec_w[0], last_w[0]} !== snap || snap[W+9] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_frozen: got %h, expected %h held with valid", 
                     {out_vld[0], dout_w[0], prec_w[0], last_w[0]}, snap);
        end
        emits = 0;
        for (int c = 0; c < 60 && (idx < 12 || emits < 12); c++) begin
            if (idx < 12) d = vals[idx];
            else d = '0;
            cycle(idx < 12, d, 1'b1, acc, emit);
            if (acc) idx++;
            if (emit) begin
                emits++;
                if (emits == BL) begin
                    n_checks++;
                    if (in_rdy[0] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bp_ready_rise: got %b, expected 1", in_rdy[0]);
                    end
                end
            end
        end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("bp beat %0d: d=%h p=%h last=%b", i, o.d[0], o.p, o.l);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_beat %0d: got %h, expected %h", i, o, e);
            end
            i++;
        end
        n_checks++;
        if (i != 12 || obs_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats, expected 12 (%0d missing)", i, exp_q.size());
        end
    endtask

    task automatic test_throughput();
        logic [W-1:0] vals [40];
        logic [W-1:0] d;
        beat_t        o, e;
        bit           acc, emit;
        int           first, last_e, n_emit, stalls, w, i;
        for (int b = 0; b < 10; b++) begin
            w = int'($urandom_range(1, W));
            for (int k = 0; k < BL; k++) vals[b * BL + k] = rand_sample(w);
        end
        first = -1;
        last_e = -1;
        n_emit = 0;
        stalls = 0;
        for (int c = 0; c < 48; c++) begin
            if (c < 40) d = vals[c];
            else d = '0;
            cycle(c < 40, d, 1'b1, acc, emit);
            if (c < 40 && !acc) stalls++;
            if (emit) begin
                n_emit++;
                if (first < 0) first = c;
                last_e = c;
            end
        end
        n_checks++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL tp_input_stalls: got %0d, expected 0", stalls);
        end
        n_checks++;
        if (n_emit != 40 || first != BL || last_e - first + 1 != 40) begin
            n_fail++;
            $display("FAIL tp_output_rate: got %0d beats over cycles %0d..%0d, expected 40 over %0d..%0d",
                     n_emit, first, last_e, BL, BL + 39);
        end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("tp beat %0d: d=%h p=%h last=%b", i, o.d[0], o.p, o.l);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL tp_beat %0d: got %h, expected %h", i, o, e);
            end
            i++;
        end
        n_checks++;
        if (i != 40 || obs_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL tp_count: got %0d beats, expected 40 (%0d missing)", i, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        beat_t o, e;
        bit    acc, emit;
        int    i;
        for (int c = 0; c < BL + 2; c++) cycle(1'b1, rand_sample(12), 1'b1, acc, emit);
        n_checks++;
        if (out_vld[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_draining: got vld=%b, expected 1", out_vld[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_checks++;
            if (in_rdy[k] !== 1'b0 || out_vld[k] !== 1'b0 || dout_w[k] !== '0 ||
                prec_w[k] !== 8'd0 || last_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_async cfg%0d: got rdy=%b vld=%b d=%h p=%0d last=%b, expected all 0",
                         k, in_rdy[k], out_vld[k], dout_w[k], prec_w[k], last_w[k]);
            end
        end
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("rstmid beat %0d: d=%h p=%h last=%b", i, o.d[0], o.p, o.l);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rstmid_pre_beat %0d: got %h, expected %h", i, o, e);
            end
            i++;
        end
        n_checks++;
        if (i != 2) begin
            n_fail++;
            $display("FAIL rstmid_pre_count: got %0d beats, expected 2", i);
        end
        // Reset discards everything still buffered.
        exp_q.delete();
        obs_q.delete();
        blk.delete();
        repeat (2) cycle(1'b1, rand_sample(8), 1'b1, acc, emit);
        rst_n = 1'b1;
        for (int c = 0; c < BL; c++) cycle(1'b1, rand_sample(int'($urandom_range(1, W))), 1'b1, acc, emit);
        repeat (BL + 2) cycle(1'b0, '0, 1'b1, acc, emit);
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("rstmid post beat %0d: d=%h p=%h last=%b", i, o.d[0], o.p, o.l);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rstmid_post_beat %0d: got %h, expected %h", i, o, e);
            end
            i++;
        end
        n_checks++;
        if (i != BL || obs_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_post_count: got %0d beats (+%0d extra), expected %0d",
                     i, obs_q.size(), BL);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
